carry_save_resolve_mod: RTL

- Downstream stage of the double-exponentiation core.
- Consumes the core's redundant carry-save result (xs, xc; value = xs + 2*xc) when the core pulses dn.
- Produces the canonical binary residue y in [0, M-1].
- Bit-serial add followed by a fixed number of conditional-subtract cycles, so latency is constant and independent of data.

---
 rtl/carry_save_resolve_mod_pkg.sv | 17 +
 rtl/carry_save_resolve_mod_bit_serial_adder.sv | 30 +++
 rtl/carry_save_resolve_mod.sv | 118 +++++++++++
 3 files changed

// File: rtl/carry_save_resolve_mod_pkg.sv
// Shared constants and state encoding for the carry-save resolve stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package carry_save_resolve_mod_pkg;

  // Word width and modulus shared with the exponentiation core.
  localparam int CSR_W = 8;
  localparam int CSR_M = 221;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RED  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/carry_save_resolve_mod_bit_serial_adder.sv
// Bit-serial full adder: one sum bit per enabled cycle, carry held in a flop.
// Latency: sum is combinational from a/b and the stored carry; the carry updates on the clock.
// Backpressure: none; en gates the carry update, clr zeroes it.
// Ports: clk, rst_n (async active-low), clr (synchronous carry clear),
//        en (advance carry), a/b (operand bits), s (sum bit).
module carry_save_resolve_mod_bit_serial_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s
);

  logic carry_q;

  assign s = a ^ b ^ carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (clr) begin
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= (a & b) | (a & carry_q) | (b & carry_q);
    end
  end

endmodule

// File: rtl/carry_save_resolve_mod.sv
// Resolves a carry-save pair (xs + 2*xc) into the canonical residue mod M.
// Latency: fixed W+3+RMAX cycles from the dn sample to the vld pulse, independent of data.
// Backpressure: none; dn is ignored while bsy is high, so the upstream must hold off.
// Ports: clk, rst_n (async active-low), dn (start strobe), xs/xc (carry-save words,
//        bit 0 is MSB), bsy (conversion in progress), vld (one-cycle result pulse),
//        y (registered residue, held until the next result or reset).
module carry_save_resolve_mod
  import carry_save_resolve_mod_pkg::*;
#(
  parameter int W = CSR_W,
  parameter int M = CSR_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dn,
  input  logic [0:W-1] xs,
  input  logic [0:W-1] xc,
  output logic         bsy,
  output logic         vld,
  output logic [0:W-1] y
);

  // Worst-case input is 3*(2^W-1); this many subtract passes always lands below M.
  localparam int RMAX = (3 * ((1 << W) - 1)) / M;
  localparam int CW   = $clog2(W + RMAX + 3);

  localparam logic [CW-1:0]  ADD_LAST = CW'(W + 1);
  localparam logic [CW-1:0]  RED_LAST = CW'(RMAX - 1);
  localparam logic [W+1:0]   MOD      = (W + 2)'(M);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_sr;
  logic [W:0]      b_sr;
  logic [W+1:0]    s_acc;
  logic [W-1:0]    y_q;
  logic            vld_q;
  logic            sum_bit;
  logic            add_clr;
  logic            add_en;

  assign add_clr = (state_q == ST_IDLE);
  assign add_en  = (state_q == ST_ADD);

  carry_save_resolve_mod_bit_serial_adder u_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (add_clr),
    .en    (add_en),
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .s     (sum_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dn) state_d = ST_ADD;
      ST_ADD:  if (cnt_q == ADD_LAST) state_d = ST_RED;
      ST_RED:  if (cnt_q == RED_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      s_acc <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dn) begin
            a_sr  <= xs;
            b_sr  <= {xc, 1'b0};
            s_acc <= '0;
            cnt_q <= '0;
          end
        end
        ST_ADD: begin
          // LSB-first addition; each sum bit enters at the top of S so that after
          // W+2 shifts the first bit produced sits at S[0].
          s_acc <= {sum_bit, s_acc[W+1:1]};
          a_sr  <= {1'b0, a_sr[W-1:1]};
          b_sr  <= {1'b0, b_sr[W:1]};
          cnt_q <= (cnt_q == ADD_LAST) ? '0 : cnt_q + 1'b1;
        end
        ST_RED: begin
          if (s_acc >= MOD) s_acc <= s_acc - MOD;
          cnt_q <= cnt_q + 1'b1;
        end
        ST_DONE: begin
          y_q   <= s_acc[W-1:0];
          vld_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bsy = (state_q != ST_IDLE);
  assign vld = vld_q;
  assign y   = y_q;

endmodule
